pwm_ramp_scheduler: RTL and testbench

Sits between the motor PWM peripheral's register file and the two PWM generators, and sequences every width change that reaches them. Updates the left and right widths only at 20 ms frame boundaries and limits the change to STEP_MAX counts per frame (slew limiting). Forces both channels to neutral (127) on pause or on a command watchdog timeout.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_slew_channel.sv | 88 ++++++++
 rtl/pwm_ramp_scheduler.sv | 135 +++++++++++++
 tb/tb_pwm_ramp_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM ramp scheduler.
package pwm_pkg;

  typedef logic [7:0] pwm_width_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSED  = 2'd1,
    TIMEOUT = 2'd2
  } sched_state_t;

  localparam pwm_width_t PWM_NEUTRAL = 8'd127;

endpackage

// File: rtl/pwm_slew_channel.sv
// One PWM channel: width register stepped toward its effective target once per frame.
// Build option PWM_RAMP_REVERSE_HOLD_EN parks the width at neutral on a direction reversal.
module pwm_slew_channel
  import pwm_pkg::*;
#(
  parameter int unsigned STEP_MAX = 8,
  parameter pwm_width_t  NEUTRAL  = PWM_NEUTRAL
`ifdef PWM_RAMP_REVERSE_HOLD_EN
  ,
  parameter int unsigned HOLD_FRAMES = 5
`endif
) (
  input  logic       clk_12MHz,
  input  logic       reset_n,
  input  logic       step,
  input  pwm_width_t eff,
  output pwm_width_t width
);

  localparam logic [9:0] StepMax = 10'(STEP_MAX);

  pwm_width_t        width_q;
  pwm_width_t        width_d;
  pwm_width_t        slew;
  logic signed [9:0] diff;
  logic        [9:0] mag;

  // When |diff| exceeds the step the +/- step cannot leave 0..255.
  always_comb begin
    diff = $signed({2'b00, eff}) - $signed({2'b00, width_q});
    mag  = diff[9] ? 10'(-diff) : 10'(diff);
    if (mag <= StepMax) begin
      slew = eff;
    end else if (diff[9]) begin
      slew = width_q - StepMax[7:0];
    end else begin
      slew = width_q + StepMax[7:0];
    end
  end

`ifdef PWM_RAMP_REVERSE_HOLD_EN
  localparam int unsigned HoldW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic [HoldW-1:0] hold_q;
  logic [HoldW-1:0] hold_d;
  logic             crossing;

  always_comb begin
    crossing = ((width_q < NEUTRAL) && (slew > NEUTRAL)) ||
               ((width_q > NEUTRAL) && (slew < NEUTRAL));
    width_d  = width_q;
    hold_d   = hold_q;
    if (step) begin
      if (hold_q != '0) begin
        hold_d = hold_q - HoldW'(1);
      end else if (crossing) begin
        width_d = NEUTRAL;
        hold_d  = HoldW'(HOLD_FRAMES);
      end else begin
        width_d = slew;
      end
    end
  end

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  always_comb begin
    width_d = step ? slew : width_q;
  end
`endif

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      width_q <= NEUTRAL;
    end else begin
      width_q <= width_d;
    end
  end

  assign width = width_q;

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Frame-synchronous, slew-limited width sequencer for the left/right PWM generators.
// Build option PWM_RAMP_REVERSE_HOLD_EN enables the neutral hold on direction reversal.
module pwm_ramp_scheduler
  import pwm_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 240000,
  parameter int unsigned STEP_MAX     = 8,
  parameter int unsigned WDOG_FRAMES  = 25,
  parameter pwm_width_t  NEUTRAL      = PWM_NEUTRAL
`ifdef PWM_RAMP_REVERSE_HOLD_EN
  ,
  parameter int unsigned HOLD_FRAMES  = 5
`endif
) (
  input  logic       clk_12MHz,
  input  logic       reset_n,
  input  logic [7:0] target_left,
  input  logic [7:0] target_right,
  input  logic       target_valid,
  input  logic       pause,
  output logic [7:0] width_left,
  output logic [7:0] width_right,
  output logic       frame_tick,
  output logic [1:0] state,
  output logic       at_target
);

  localparam int unsigned      CntW    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned      WdogW   = $clog2(WDOG_FRAMES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(FRAME_CYCLES - 1);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(WDOG_FRAMES);

  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;
  logic             boundary;
  logic             frame_tick_q;
  logic [WdogW-1:0] wdog_q;
  logic [WdogW-1:0] wdog_d;
  logic             wdog_expire;
  pwm_width_t       tgt_left_q;
  pwm_width_t       tgt_right_q;
  pwm_width_t       eff_left;
  pwm_width_t       eff_right;
  pwm_width_t       w_left;
  pwm_width_t       w_right;
  sched_state_t     state_q;
  sched_state_t     state_d;

  // A command on the boundary cycle wins over the increment, so no timeout that frame.
  always_comb begin
    boundary    = (cnt_q == CntLast);
    cnt_d       = boundary ? '0 : cnt_q + CntW'(1);
    wdog_d      = wdog_q;
    if (target_valid) begin
      wdog_d = '0;
    end else if (boundary && (wdog_q != WdogMax)) begin
      wdog_d = wdog_q + WdogW'(1);
    end
    wdog_expire = boundary && !target_valid && (wdog_q >= WdogMax - WdogW'(1));
  end

  always_comb begin
    state_d = state_q;
    if (pause) begin
      state_d = PAUSED;
    end else begin
      unique case (state_q)
        RUN:     if (wdog_expire) state_d = TIMEOUT;
        PAUSED:  state_d = TIMEOUT;
        TIMEOUT: if (target_valid) state_d = RUN;
        default: state_d = TIMEOUT;
      endcase
    end
  end

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      wdog_q       <= '0;
      state_q      <= TIMEOUT;
      tgt_left_q   <= NEUTRAL;
      tgt_right_q  <= NEUTRAL;
    end else begin
      cnt_q        <= cnt_d;
      frame_tick_q <= boundary;
      wdog_q       <= wdog_d;
      state_q      <= state_d;
      if (target_valid) begin
        tgt_left_q  <= target_left;
        tgt_right_q <= target_right;
      end
    end
  end

  assign eff_left  = (state_q == RUN) ? tgt_left_q : NEUTRAL;
  assign eff_right = (state_q == RUN) ? tgt_right_q : NEUTRAL;

  pwm_slew_channel #(
    .STEP_MAX    (STEP_MAX),
    .NEUTRAL     (NEUTRAL)
`ifdef PWM_RAMP_REVERSE_HOLD_EN
    ,
    .HOLD_FRAMES (HOLD_FRAMES)
`endif
  ) u_left (
    .clk_12MHz (clk_12MHz),
    .reset_n   (reset_n),
    .step      (boundary),
    .eff       (eff_left),
    .width     (w_left)
  );

  pwm_slew_channel #(
    .STEP_MAX    (STEP_MAX),
    .NEUTRAL     (NEUTRAL)
`ifdef PWM_RAMP_REVERSE_HOLD_EN
    ,
    .HOLD_FRAMES (HOLD_FRAMES)
`endif
  ) u_right (
    .clk_12MHz (clk_12MHz),
    .reset_n   (reset_n),
    .step      (boundary),
    .eff       (eff_right),
    .width     (w_right)
  );

  assign width_left  = w_left;
  assign width_right = w_right;
  assign frame_tick  = frame_tick_q;
  assign state       = state_q;
  assign at_target   = (w_left == eff_left) && (w_right == eff_right);

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Self-checking bench for pwm_ramp_scheduler with a frame-level reference model.
module tb_pwm_ramp_scheduler;

  localparam int FRAME_CYCLES = 100;
  localparam int STEP_MAX     = 16;
  localparam int WDOG_FRAMES  = 4;
  localparam int NEUTRAL      = 127;
`ifdef PWM_RAMP_REVERSE_HOLD_EN
  localparam int HOLD_FRAMES  = 2;
`endif
  localparam int S_RUN     = 0;
  localparam int S_PAUSED  = 1;
  localparam int S_TIMEOUT = 2;

  logic       clk_12MHz = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] target_left = 8'd0;
  logic [7:0] target_right = 8'd0;
  logic       target_valid = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] width_left;
  logic [7:0] width_right;
  logic       frame_tick;
  logic [1:0] state;
  logic       at_target;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_w_l, m_w_r, m_h_l, m_h_r, m_tgt_l, m_tgt_r, m_state, m_wdog, m_cnt;
  bit m_tick;
  int stab_err = 0;

  always #5 clk_12MHz = ~clk_12MHz;

  pwm_ramp_scheduler #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .STEP_MAX     (STEP_MAX),
    .WDOG_FRAMES  (WDOG_FRAMES)
`ifdef PWM_RAMP_REVERSE_HOLD_EN
    ,
    .HOLD_FRAMES  (HOLD_FRAMES)
`endif
  ) dut (
    .clk_12MHz    (clk_12MHz),
    .reset_n      (reset_n),
    .target_left  (target_left),
    .target_right (target_right),
    .target_valid (target_valid),
    .pause        (pause),
    .width_left   (width_left),
    .width_right  (width_right),
    .frame_tick   (frame_tick),
    .state        (state),
    .at_target    (at_target)
  );

  function automatic int slew(input int w, input int e);
    int d;
    d = e - w;
    if (d >= -STEP_MAX && d <= STEP_MAX) return e;
    return (d > 0) ? w + STEP_MAX : w - STEP_MAX;
  endfunction

  function automatic void advance(input int w, input int e, input int h,
                                  output int wn, output int hn);
    int n;
    n  = slew(w, e);
    wn = n;
    hn = h;
`ifdef PWM_RAMP_REVERSE_HOLD_EN
    if (h > 0) begin
      wn = w;
      hn = h - 1;
    end else if ((w < NEUTRAL && n > NEUTRAL) || (w > NEUTRAL && n < NEUTRAL)) begin
      wn = NEUTRAL;
      hn = HOLD_FRAMES;
    end
`endif
  endfunction

  function automatic bit model_at_target();
    int el, er;
    el = (m_state == S_RUN) ? m_tgt_l : NEUTRAL;
    er = (m_state == S_RUN) ? m_tgt_r : NEUTRAL;
    return (m_w_l == el) && (m_w_r == er);
  endfunction

  task automatic model_reset();
    m_w_l = NEUTRAL; m_w_r = NEUTRAL; m_h_l = 0; m_h_r = 0;
    m_tgt_l = NEUTRAL; m_tgt_r = NEUTRAL; m_state = S_TIMEOUT;
    m_wdog = 0; m_cnt = 0; m_tick = 1'b0;
  endtask

  // One clock: sample inputs, advance the DUT and the model by one edge.
  task automatic step_clk();
    bit bnd, expire, tv, pz;
    int tl, tr, dl, dr, el, er, nl, nr, hl, hr;
    bnd = (m_cnt == FRAME_CYCLES - 1);
    tv = target_valid; pz = pause; tl = target_left; tr = target_right;
    dl = width_left; dr = width_right;
    @(posedge clk_12MHz);
    #1;
    if (bnd) begin
      el = (m_state == S_RUN) ? m_tgt_l : NEUTRAL;
      er = (m_state == S_RUN) ? m_tgt_r : NEUTRAL;
      advance(m_w_l, el, m_h_l, nl, hl);
      advance(m_w_r, er, m_h_r, nr, hr);
      m_w_l = nl; m_h_l = hl; m_w_r = nr; m_h_r = hr;
    end
    expire = bnd && !tv && (m_state == S_RUN) && (m_wdog + 1 >= WDOG_FRAMES);
    if (tv) m_wdog = 0;
    else if (bnd && m_wdog < WDOG_FRAMES) m_wdog++;
    if (tv) begin m_tgt_l = tl; m_tgt_r = tr; end
    if (pz) m_state = S_PAUSED;
    else if (m_state == S_RUN && expire) m_state = S_TIMEOUT;
    else if (m_state == S_PAUSED) m_state = S_TIMEOUT;
    else if (m_state == S_TIMEOUT && tv) m_state = S_RUN;
    m_cnt  = bnd ? 0 : m_cnt + 1;
    m_tick = bnd;
    if (!bnd && (int'(width_left) != dl || int'(width_right) != dr)) stab_err++;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (frame_tick !== 1'b1 && n < 2 * FRAME_CYCLES);
    if (frame_tick !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_tick: frame_tick=%b after %0d cycles, want 1", frame_tick, n);
    end
  endtask

  task automatic send_cmd(input int l, input int r);
    while (m_cnt == FRAME_CYCLES - 1) step_clk();
    target_left = 8'(l); target_right = 8'(r); target_valid = 1'b1;
    step_clk();
    target_valid = 1'b0;
  endtask

  task automatic run_to(input int l, input int r);
    int n;
    send_cmd(l, r);
    for (int i = 0; i < 40; i++) begin
      wait_tick(n);
      if (m_w_l == l && m_w_r == r) break;
      if (i % 2 == 1) send_cmd(l, r);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_12MHz);
    #1;
    checks++; if (width_left !== 8'd127) begin failures++;
      $display("FAIL reset_wl: got %0d want 127", width_left); end
    checks++; if (width_right !== 8'd127) begin failures++;
      $display("FAIL reset_wr: got %0d want 127", width_right); end
    checks++; if (state !== 2'd2) begin failures++;
      $display("FAIL reset_state: got %0d want 2", state); end
    checks++; if (frame_tick !== 1'b0) begin failures++;
      $display("FAIL reset_tick: got %b want 0", frame_tick); end
    checks++; if (at_target !== 1'b1) begin failures++;
      $display("FAIL reset_at_target: got %b want 1", at_target); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    int exp_l[5] = '{143, 159, 175, 191, 200};
    int exp_r[5] = '{111, 95, 79, 63, 50};
    int n;
    repeat (5) step_clk();
    send_cmd(200, 50);
    checks++; if (state !== 2'd0) begin failures++;
      $display("FAIL ramp_state: got %0d want 0", state); end
    for (int k = 0; k < 5; k++) begin
      wait_tick(n);
      if (k == 1) begin
        checks++; if (n != FRAME_CYCLES) begin failures++;
          $display("FAIL frame_period: got %0d want %0d", n, FRAME_CYCLES); end
      end
      checks++; if (width_left !== 8'(exp_l[k])) begin failures++;
        $display("FAIL ramp_wl tick %0d: got %0d want %0d", k + 1, width_left, exp_l[k]); end
      checks++; if (width_right !== 8'(exp_r[k])) begin failures++;
        $display("FAIL ramp_wr tick %0d: got %0d want %0d", k + 1, width_right, exp_r[k]); end
      checks++; if (at_target !== (k == 4)) begin failures++;
        $display("FAIL ramp_at_target tick %0d: got %b want %b", k + 1, at_target, k == 4); end
      if (k == 1) send_cmd(200, 50);
    end
  endtask

  task automatic test_boundary_cmd();
    int n, rr;
    run_to(127, 127);
    send_cmd(127, 127);
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      checks++; if (state !== 2'd0) begin failures++;
        $display("FAIL bnd_idle_state tick %0d: got %0d want 0", k + 1, state); end
    end
    rr = $urandom_range(100, 160);
    while (m_cnt != FRAME_CYCLES - 1) step_clk();
    target_left = 8'd130; target_right = 8'(rr); target_valid = 1'b1;
    step_clk();
    target_valid = 1'b0;
    checks++; if (frame_tick !== 1'b1) begin failures++;
      $display("FAIL bnd_tick: got %b want 1", frame_tick); end
    checks++; if (width_left !== 8'd127) begin failures++;
      $display("FAIL bnd_wl_same: got %0d want 127", width_left); end
    checks++; if (state !== 2'd0) begin failures++;
      $display("FAIL bnd_no_timeout: got %0d want 0", state); end
    wait_tick(n);
    checks++; if (width_left !== 8'd130) begin failures++;
      $display("FAIL bnd_wl_next: got %0d want 130", width_left); end
    checks++; if (width_right !== 8'(m_w_r)) begin failures++;
      $display("FAIL bnd_wr_next: got %0d want %0d", width_right, m_w_r); end
  endtask

  task automatic test_watchdog();
    int n, rr, e;
    rr = $urandom_range(0, 255);
    run_to(200, rr);
    send_cmd(200, rr);
    for (int k = 1; k <= 4; k++) begin
      wait_tick(n);
      checks++; if (state !== ((k == 4) ? 2'd2 : 2'd0)) begin failures++;
        $display("FAIL wdog_state tick %0d: got %0d want %0d", k, state, (k == 4) ? 2 : 0); end
      checks++; if (width_left !== 8'd200) begin failures++;
        $display("FAIL wdog_hold tick %0d: got %0d want 200", k, width_left); end
    end
    for (int k = 1; k <= 6; k++) begin
      wait_tick(n);
      e = (200 - STEP_MAX * k < NEUTRAL) ? NEUTRAL : 200 - STEP_MAX * k;
      checks++; if (width_left !== 8'(e)) begin failures++;
        $display("FAIL wdog_ramp_wl tick %0d: got %0d want %0d", k, width_left, e); end
      checks++; if (width_right !== 8'(m_w_r)) begin failures++;
        $display("FAIL wdog_ramp_wr tick %0d: got %0d want %0d", k, width_right, m_w_r); end
    end
  endtask

  task automatic test_pause();
    int n, e;
    send_cmd(200, $urandom_range(0, 255));
    checks++; if (state !== 2'd0) begin failures++;
      $display("FAIL pause_start_state: got %0d want 0", state); end
    repeat (3) wait_tick(n);
    checks++; if (width_left !== 8'd175) begin failures++;
      $display("FAIL pause_pre_wl: got %0d want 175", width_left); end
    pause = 1'b1;
    step_clk();
    checks++; if (state !== 2'd1) begin failures++;
      $display("FAIL pause_state: got %0d want 1", state); end
    for (int k = 1; k <= 4; k++) begin
      wait_tick(n);
      e = (175 - STEP_MAX * k < NEUTRAL) ? NEUTRAL : 175 - STEP_MAX * k;
      checks++; if (width_left !== 8'(e)) begin failures++;
        $display("FAIL pause_ramp_wl tick %0d: got %0d want %0d", k, width_left, e); end
      checks++; if (width_right !== 8'(m_w_r)) begin failures++;
        $display("FAIL pause_ramp_wr tick %0d: got %0d want %0d", k, width_right, m_w_r); end
    end
    send_cmd($urandom_range(0, 255), $urandom_range(0, 255));
    checks++; if (state !== 2'd1) begin failures++;
      $display("FAIL pause_cmd_state: got %0d want 1", state); end
    wait_tick(n);
    checks++; if (width_left !== 8'd127) begin failures++;
      $display("FAIL pause_cmd_wl: got %0d want 127", width_left); end
    pause = 1'b0;
    step_clk();
    checks++; if (state !== 2'd2) begin failures++;
      $display("FAIL unpause_state: got %0d want 2", state); end
    repeat (2) wait_tick(n);
    checks++; if (width_left !== 8'd127 || width_right !== 8'd127) begin failures++;
      $display("FAIL unpause_w: got %0d/%0d want 127/127", width_left, width_right); end
    checks++; if (at_target !== 1'b1) begin failures++;
      $display("FAIL unpause_at_target: got %b want 1", at_target); end
    send_cmd($urandom_range(0, 255), $urandom_range(0, 255));
    checks++; if (state !== 2'd0) begin failures++;
      $display("FAIL resume_state: got %0d want 0", state); end
  endtask

  task automatic test_reset_midramp();
    int n;
    run_to(127, 127);
    send_cmd(255, 0);
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      if (k == 1) send_cmd(255, 0);
    end
    checks++; if (width_left !== 8'd191) begin failures++;
      $display("FAIL midramp_pre_wl: got %0d want 191", width_left); end
    reset_n = 1'b0;
    #1;
    checks++; if (width_left !== 8'd127 || width_right !== 8'd127) begin failures++;
      $display("FAIL async_reset_w: got %0d/%0d want 127/127", width_left, width_right); end
    checks++; if (state !== 2'd2) begin failures++;
      $display("FAIL async_reset_state: got %0d want 2", state); end
    checks++; if (frame_tick !== 1'b0) begin failures++;
      $display("FAIL async_reset_tick: got %b want 0", frame_tick); end
    repeat (2) @(posedge clk_12MHz);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reversal();
`ifdef PWM_RAMP_REVERSE_HOLD_EN
    int exp_w[7] = '{116, 127, 127, 127, 143, 159, 160};
`else
    int exp_w[4] = '{116, 132, 148, 160};
`endif
    int n;
    run_to(100, 100);
    send_cmd(160, 160);
    for (int k = 0; k < $size(exp_w); k++) begin
      wait_tick(n);
      checks++; if (width_left !== 8'(exp_w[k]) || width_right !== 8'(exp_w[k])) begin
        failures++;
        $display("FAIL reversal tick %0d: got %0d/%0d want %0d", k + 1, width_left,
                 width_right, exp_w[k]);
      end
      if (k % 2 == 1) send_cmd(160, 160);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 40 * FRAME_CYCLES; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        target_left  = 8'($urandom);
        target_right = 8'($urandom);
        target_valid = 1'b1;
      end else begin
        target_valid = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) pause = ~pause;
      step_clk();
      if (m_tick) begin
        checks++;
        if (width_left !== 8'(m_w_l) || width_right !== 8'(m_w_r) ||
            state !== 2'(m_state) || at_target !== model_at_target()) begin
          failures++;
          $display("FAIL random cycle %0d: got w=%0d/%0d st=%0d at=%b want w=%0d/%0d st=%0d at=%b",
                   c, width_left, width_right, state, at_target, m_w_l, m_w_r, m_state,
                   model_at_target());
        end
      end
    end
    target_valid = 1'b0;
    pause = 1'b0;
    checks++; if (stab_err != 0) begin failures++;
      $display("FAIL width_stable: got %0d mid-frame changes want 0", stab_err); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_boundary_cmd();
    test_watchdog();
    test_pause();
    test_reset_midramp();
    test_reversal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
